// File: rtl/clk_div_prog.sv
// Programmable glitch-free integer clock divider: square/pulse output, period tick, pending divisor reload.
// Define CLKDIV_CNT_EN to add the periods_out completed-period counter.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DIV_DEFAULT = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load_in,
    input  logic             mode_in,
    output logic             clk_out,
    output logic             tick_out,
    output logic             pend_out,
    output logic [WIDTH-1:0] div_cur_out
`ifdef CLKDIV_CNT_EN
    ,
    output logic [CNT_W-1:0] periods_out
`endif
);

    localparam logic [WIDTH-1:0] DivRst = WIDTH'(DIV_DEFAULT);
    localparam logic [WIDTH-1:0] CntRst = WIDTH'(DIV_DEFAULT - 1);

    if (DIV_DEFAULT < 2 || 64'(DIV_DEFAULT) >= (64'(1) << WIDTH) || CNT_W < 1) begin : g_bad_params
        $error("clk_div_prog: DIV_DEFAULT must be in [2, 2^WIDTH) and CNT_W >= 1");
    end

    // Divisors of 0 or 1 cannot form a period with both a high and a low phase.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    // ceil(d/2) computed one bit wider so d = 2^WIDTH-1 does not overflow.
    function automatic logic [WIDTH-1:0] half_div(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] s;
        s = {1'b0, d} + {{WIDTH{1'b0}}, 1'b1};
        return s[WIDTH:1];
    endfunction

    function automatic logic wave_level(input logic [WIDTH-1:0] cnt,
                                        input logic [WIDTH-1:0] d,
                                        input logic             pulse);
        return pulse ? (cnt == '0) : (cnt < half_div(d));
    endfunction

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic             pmode_q, pmode_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             last_cnt;
    logic             boundary;
    logic [WIDTH-1:0] load_div;

    assign last_cnt = (cnt_q == div_q - WIDTH'(1));
    assign boundary = en_in & last_cnt;
    assign load_div = clamp_div(div_in);

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        pdiv_d  = pdiv_q;
        pmode_d = pmode_q;
        pend_d  = pend_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        if (boundary) begin
            // New divisor/mode take effect together with cnt=0, so the next period starts clean.
            cnt_d = '0;
            if (load_in) begin
                div_d  = load_div;
                mode_d = mode_in;
                pend_d = 1'b0;
            end else if (pend_q) begin
                div_d  = pdiv_q;
                mode_d = pmode_q;
                pend_d = 1'b0;
            end
            clk_d  = wave_level(cnt_d, div_d, mode_d);
            tick_d = (cnt_d == div_d - WIDTH'(1));
        end else begin
            if (load_in) begin
                pdiv_d  = load_div;
                pmode_d = mode_in;
                pend_d  = 1'b1;
            end
            if (en_in) begin
                cnt_d  = cnt_q + WIDTH'(1);
                clk_d  = wave_level(cnt_d, div_q, mode_q);
                tick_d = (cnt_d == div_q - WIDTH'(1));
            end
        end
    end

    // Starting at DIV_DEFAULT-1 makes the first enabled edge a boundary, so the first period is full.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q  <= CntRst;
            div_q  <= DivRst;
            mode_q <= 1'b0;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    // Pending values are only meaningful while pend_q is set, so they need no reset.
    always_ff @(posedge clk_in) begin
        pdiv_q  <= pdiv_d;
        pmode_q <= pmode_d;
    end

    assign clk_out     = clk_q;
    assign tick_out    = tick_q;
    assign pend_out    = pend_q;
    assign div_cur_out = div_q;

`ifdef CLKDIV_CNT_EN
    logic [CNT_W-1:0] per_q, per_d;

    always_comb begin
        per_d = per_q;
        if (boundary) begin
            per_d = per_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    assign periods_out = per_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a period-queue reference model.
module tb_clk_div_prog;

    localparam int W  = 16;
    localparam int CW = 8;   // narrow period counter so its wrap is reachable quickly

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          en_in = 1'b0;
    logic [W-1:0]  div_in = '0;
    logic          load_in = 1'b0;
    logic          mode_in = 1'b0;
    logic          clk_out, tick_out, pend_out;
    logic [W-1:0]  div_cur_out;
`ifdef CLKDIV_CNT_EN
    logic [CW-1:0] periods_out;
`endif

    clk_div_prog #(.WIDTH(W), .DIV_DEFAULT(4), .CNT_W(CW)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_in       (en_in),
        .div_in      (div_in),
        .load_in     (load_in),
        .mode_in     (mode_in),
        .clk_out     (clk_out),
        .tick_out    (tick_out),
        .pend_out    (pend_out),
        .div_cur_out (div_cur_out)
`ifdef CLKDIV_CNT_EN
        ,
        .periods_out (periods_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: each period is materialised as a queue of (clk, tick) output values.
    bit qc[$];
    bit qt[$];
    int m_D = 4;
    bit m_M = 0;
    bit m_pend = 0;
    int m_PD = 2;
    bit m_PM = 0;
    bit m_clk = 0;
    bit m_tick = 0;
    int m_periods = 0;

    function automatic int clampd(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_step();
        if (rst_in) begin
            qc.delete(); qt.delete();
            m_D = 4; m_M = 0; m_pend = 0; m_clk = 0; m_tick = 0; m_periods = 0;
        end else if (en_in) begin
            if (qc.size() == 0) begin
                if (load_in) begin
                    m_D = clampd(int'(div_in)); m_M = mode_in; m_pend = 0;
                end else if (m_pend) begin
                    m_D = m_PD; m_M = m_PM; m_pend = 0;
                end
                for (int k = 0; k < m_D; k++) begin
                    qc.push_back(m_M ? (k == 0) : (k < (m_D + 1) / 2));
                    qt.push_back(k == m_D - 1);
                end
                m_periods = (m_periods + 1) % (1 << CW);
            end else if (load_in) begin
                m_PD = clampd(int'(div_in)); m_PM = mode_in; m_pend = 1;
            end
            m_clk  = qc.pop_front();
            m_tick = qt.pop_front();
        end else begin
            if (load_in) begin
                m_PD = clampd(int'(div_in)); m_PM = mode_in; m_pend = 1;
            end
            m_tick = 0;
        end
    endtask

    task automatic model_check();
        chk("model_clk", 32'(clk_out), 32'(m_clk));
        chk("model_tick", 32'(tick_out), 32'(m_tick));
        chk("model_pend", 32'(pend_out), 32'(m_pend));
        chk("model_div_cur", 32'(div_cur_out), 32'(m_D));
`ifdef CLKDIV_CNT_EN
        chk("model_periods", 32'(periods_out), 32'(m_periods));
`endif
    endtask

    task automatic cyc(input bit r, input bit e, input bit l, input int d, input bit m);
        rst_in = r; en_in = e; load_in = l; div_in = W'(d); mode_in = m;
        @(posedge clk_in);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        bit r, e, l;
        int d;
        bit m;
        bit c, t, p;
        int dc;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t v(bit r, bit e, bit l, int d, bit m, bit c, bit t, bit p, int dc);
        vec_t x;
        x.r = r; x.e = e; x.l = l; x.d = d; x.m = m;
        x.c = c; x.t = t; x.p = p; x.dc = dc;
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;

        // Reset, default 1,1,0,0; load 5 mid-period; clamp 0 and 1; pulse D=6; reset with load pending.
        tab.push_back(v(1,0,0,0,0, 0,0,0,4));
        tab.push_back(v(0,1,0,0,0, 1,0,0,4));
        tab.push_back(v(0,1,0,0,0, 1,0,0,4));
        tab.push_back(v(0,1,0,0,0, 0,0,0,4));
        tab.push_back(v(0,1,0,0,0, 0,1,0,4));
        tab.push_back(v(0,1,0,0,0, 1,0,0,4));
        tab.push_back(v(0,1,1,5,0, 1,0,1,4));
        tab.push_back(v(0,1,0,0,0, 0,0,1,4));
        tab.push_back(v(0,1,0,0,0, 0,1,1,4));
        tab.push_back(v(0,1,0,0,0, 1,0,0,5));
        tab.push_back(v(0,1,0,0,0, 1,0,0,5));
        tab.push_back(v(0,1,0,0,0, 1,0,0,5));
        tab.push_back(v(0,1,0,0,0, 0,0,0,5));
        tab.push_back(v(0,1,0,0,0, 0,1,0,5));
        tab.push_back(v(0,1,0,0,0, 1,0,0,5));
        tab.push_back(v(0,1,1,0,0, 1,0,1,5));
        tab.push_back(v(0,1,0,0,0, 1,0,1,5));
        tab.push_back(v(0,1,0,0,0, 0,0,1,5));
        tab.push_back(v(0,1,0,0,0, 0,1,1,5));
        tab.push_back(v(0,1,0,0,0, 1,0,0,2));
        tab.push_back(v(0,1,0,0,0, 0,1,0,2));
        tab.push_back(v(0,1,1,1,0, 1,0,0,2));
        tab.push_back(v(0,1,1,6,1, 0,1,1,2));
        tab.push_back(v(0,1,0,0,0, 1,0,0,6));
        tab.push_back(v(0,1,0,0,0, 0,0,0,6));
        tab.push_back(v(0,1,0,0,0, 0,0,0,6));
        tab.push_back(v(0,1,0,0,0, 0,0,0,6));
        tab.push_back(v(0,1,0,0,0, 0,0,0,6));
        tab.push_back(v(0,1,0,0,0, 0,1,0,6));
        tab.push_back(v(0,1,0,0,0, 1,0,0,6));
        tab.push_back(v(0,1,1,9,0, 0,0,1,6));
        tab.push_back(v(1,1,0,0,0, 0,0,0,4));
        tab.push_back(v(0,1,0,0,0, 1,0,0,4));
        tab.push_back(v(0,1,0,0,0, 1,0,0,4));
        tab.push_back(v(0,1,0,0,0, 0,0,0,4));
        tab.push_back(v(0,1,0,0,0, 0,1,0,4));
        tab.push_back(v(0,1,0,0,0, 1,0,0,4));

        for (int i = 0; i < tab.size(); i++) begin
            cyc(tab[i].r, tab[i].e, tab[i].l, tab[i].d, tab[i].m);
            chk($sformatf("vec%0d_clk", i), 32'(clk_out), 32'(tab[i].c));
            chk($sformatf("vec%0d_tick", i), 32'(tick_out), 32'(tab[i].t));
            chk($sformatf("vec%0d_pend", i), 32'(pend_out), 32'(tab[i].p));
            chk($sformatf("vec%0d_div_cur", i), 32'(div_cur_out), 32'(tab[i].dc));
        end

        // D=8, reload 2 at cnt=3: old period completes, then 1,0 pattern.
        cyc(1,0,0,0,0);
        cyc(0,1,1,8,0);
        chk("d8_apply_div", 32'(div_cur_out), 32'd8);
        chk("d8_apply_clk", 32'(clk_out), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cyc(0,1,0,0,0);
            chk($sformatf("d8_cnt%0d_clk", i), 32'(clk_out), 32'd1);
        end
        cyc(0,1,1,2,0);
        chk("d8_load_pend", 32'(pend_out), 32'd1);
        chk("d8_load_clk", 32'(clk_out), 32'd0);
        chk("d8_load_div", 32'(div_cur_out), 32'd8);
        for (int i = 5; i <= 7; i++) begin
            cyc(0,1,0,0,0);
            chk($sformatf("d8_cnt%0d_pend", i), 32'(pend_out), 32'd1);
            chk($sformatf("d8_cnt%0d_tick", i), 32'(tick_out), 32'(i == 7));
            chk($sformatf("d8_cnt%0d_div", i), 32'(div_cur_out), 32'd8);
        end
        cyc(0,1,0,0,0);
        chk("d2_apply_clk", 32'(clk_out), 32'd1);
        chk("d2_apply_pend", 32'(pend_out), 32'd0);
        chk("d2_apply_div", 32'(div_cur_out), 32'd2);
        cyc(0,1,0,0,0);
        chk("d2_low_clk", 32'(clk_out), 32'd0);
        chk("d2_low_tick", 32'(tick_out), 32'd1);

        // Stall at cnt=1 for 3 cycles stretches a D=4 period to 7.
        cyc(1,0,0,0,0);
        cyc(0,1,0,0,0);
`ifdef CLKDIV_CNT_EN
        chk("stall_periods_first", 32'(periods_out), 32'd1);
`endif
        cyc(0,1,0,0,0);
        for (int i = 0; i < 3; i++) begin
            cyc(0,0,0,0,0);
            chk($sformatf("stall%0d_clk", i), 32'(clk_out), 32'd1);
            chk($sformatf("stall%0d_tick", i), 32'(tick_out), 32'd0);
        end
        len = 5;
        for (int k = 0; k < 20; k++) begin
            cyc(0,1,0,0,0);
            if (clk_out === 1'b1) break;
            len++;
        end
        chk("stall_period_len", 32'(len), 32'd7);
`ifdef CLKDIV_CNT_EN
        chk("stall_periods_second", 32'(periods_out), 32'd2);

        // Period counter wrap at 2^CW-1 -> 0 with D=4.
        cyc(1,0,0,0,0);
        cyc(0,1,0,0,0);
        repeat (254 * 4) cyc(0,1,0,0,0);
        chk("periods_max", 32'(periods_out), 32'((1 << CW) - 1));
        repeat (4) cyc(0,1,0,0,0);
        chk("periods_wrap", 32'(periods_out), 32'd0);
`endif

        // Randomized traffic against the model.
        cyc(1,0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 9) == 0,
                int'($urandom_range(0, 11)),
                $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
